// File: rtl/framing_pkg.sv
// rtl/framing_pkg.sv - shared encodings and constants for the framing path
package framing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_EMIT      = 3'd2,
        ST_WAIT_DOWN = 3'd3,
        ST_GUARD     = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam int          FIFO_CAPACITY = 20;

endpackage

// File: rtl/crc16_step.sv
// rtl/crc16_step.sv - one-byte CRC-16/CCITT-FALSE update, MSB first
module crc16_step
    import framing_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/frame_crc_appender.sv
// rtl/frame_crc_appender.sv - buffers a payload frame and emits it with CRC-16 appended
module frame_crc_appender
    import framing_pkg::*;
#(
    parameter int MAX_PAYLOAD  = 18,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       ds_indicator,
    output logic       error
);

    localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int RD_W   = LEN_W + 1;
    localparam int BUF_AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int GC_W   = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PAYLOAD);
    localparam logic [GC_W-1:0]  GUARD_END = GC_W'(GUARD_CYCLES);

    state_t            state, next_state;
    logic [7:0]        payload_mem [MAX_PAYLOAD];
    logic [LEN_W-1:0]  len;
    logic [RD_W-1:0]   rd_idx;
    logic [15:0]       crc, crc_seed, crc_next;
    logic              ind_seen;
    logic [GC_W-1:0]   guard_cnt;

    logic              accept, overflow, emit_done;
    logic [BUF_AW-1:0] wr_idx;
    logic [7:0]        emit_byte, dout_d;
    logic              dout_valid_d, error_d;

    assign accept    = din_valid & din_ready;
    // A byte arriving with the buffer already full cannot be stored, so the frame is dropped.
    assign overflow  = (state == ST_COLLECT) && accept && (len == LEN_MAX);
    assign emit_done = (rd_idx == ({1'b0, len} + RD_W'(1)));
    assign wr_idx    = (state == ST_IDLE) ? '0 : len[BUF_AW-1:0];
    assign crc_seed  = (state == ST_IDLE) ? CRC_INIT : crc;

    crc16_step u_crc_step (
        .crc_in  (crc_seed),
        .data    (din),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (accept) next_state = din_last ? ST_EMIT : ST_COLLECT;
            ST_COLLECT:   if (overflow) next_state = ST_IDLE;
                          else if (accept && din_last) next_state = ST_EMIT;
            ST_EMIT:      if (emit_done) next_state = ST_WAIT_DOWN;
            ST_WAIT_DOWN: if (ds_indicator && ind_seen) next_state = ST_GUARD;
            ST_GUARD:     if (guard_cnt == GUARD_END) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        din_ready = (state == ST_IDLE) || (state == ST_COLLECT);
        if (rd_idx < {1'b0, len}) begin
            emit_byte = payload_mem[rd_idx[BUF_AW-1:0]];
        end else if (rd_idx == {1'b0, len}) begin
            emit_byte = crc[15:8];
        end else begin
            emit_byte = crc[7:0];
        end
        dout_valid_d = (state == ST_EMIT);
        dout_d       = dout_valid_d ? emit_byte : 8'h00;
        error_d      = overflow;
    end

    always_ff @(posedge clk) begin
        if (accept && !overflow) begin
            payload_mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len        <= '0;
            crc        <= '0;
            rd_idx     <= '0;
            ind_seen   <= 1'b0;
            guard_cnt  <= '0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            error      <= error_d;
            case (state)
                ST_IDLE: begin
                    rd_idx    <= '0;
                    ind_seen  <= 1'b0;
                    guard_cnt <= '0;
                    if (accept) begin
                        len <= LEN_W'(1);
                        crc <= crc_next;
                    end
                end
                ST_COLLECT: begin
                    if (overflow) begin
                        len <= '0;
                    end else if (accept) begin
                        len <= len + LEN_W'(1);
                        crc <= crc_next;
                    end
                end
                ST_EMIT: rd_idx <= rd_idx + RD_W'(1);
                ST_WAIT_DOWN: begin
                    guard_cnt <= '0;
                    if (ds_indicator) ind_seen <= 1'b1;
                end
                ST_GUARD: begin
                    ind_seen  <= 1'b0;
                    guard_cnt <= guard_cnt + GC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_crc_appender.sv
// tb/tb_frame_crc_appender.sv - scoreboard bench for frame_crc_appender
module tb_frame_crc_appender;

    localparam int MAXP = 18;
    localparam int G    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid, din_last, din_ready;
    logic [7:0] dout;
    logic       dout_valid, ds_indicator, error;

    frame_crc_appender #(.MAX_PAYLOAD(MAXP), .GUARD_CYCLES(G)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .ds_indicator(ds_indicator), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int exp_err = 0, err_cycles = 0, burst = 0;
    bit mon_en = 1'b0;
    logic [7:0] cur[$];
    logic [7:0] exp_byte_q[$];
    int         exp_len_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Bit-serial polynomial division over the message, MSB first.
    function automatic logic [15:0] model_crc();
        logic [15:0] r = 16'hFFFF;
        logic fb;
        foreach (cur[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[15] ^ cur[i][b];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return r;
    endfunction

    task automatic push_expected(input logic [15:0] crc, input int limit);
        logic [7:0] all[$];
        all = cur;
        all.push_back(crc[15:8]);
        all.push_back(crc[7:0]);
        for (int i = 0; i < limit; i++) exp_byte_q.push_back(all[i]);
        exp_len_q.push_back(limit);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid) begin
                if (exp_byte_q.size() == 0) check("no_unexpected_output", {31'd0, dout_valid}, 32'd0);
                else check("dout_byte", {24'd0, dout}, {24'd0, exp_byte_q.pop_front()});
                burst++;
            end else begin
                check("dout_zero_when_idle", {24'd0, dout}, 32'd0);
                if (burst > 0) begin
                    if (exp_len_q.size() == 0) check("burst_unexpected", burst, 0);
                    else check("burst_length", burst, exp_len_q.pop_front());
                    burst = 0;
                end
            end
            if (error) err_cycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input bit with_last, input int gap_after, input int gap_len, input bit rand_gaps);
        int g;
        for (int i = 0; i < cur.size(); i++) begin
            din = cur[i];
            din_valid = 1'b1;
            din_last = with_last && (i == cur.size() - 1);
            step();
            din_valid = 1'b0;
            din_last = 1'b0;
            din = 8'h00;
            if (i < cur.size() - 1) begin
                g = (i == gap_after) ? gap_len : 0;
                if (rand_gaps && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
                repeat (g) step();
            end
        end
    endtask

    // Called just after the edge that accepted the last byte of an n-byte frame.
    task automatic finish_frame(input int n, input bit hold_next);
        int m_wait;
        check("ready_low_after_last", {31'd0, din_ready}, 32'd0);
        ds_indicator = 1'b1;
        step();
        ds_indicator = 1'b0;
        repeat (n + 1 + $urandom_range(0, 3)) step();
        check("ready_low_wait_down", {31'd0, din_ready}, 32'd0);
        ds_indicator = 1'b1;
        step();
        ds_indicator = 1'b0;
        m_wait = $urandom_range(0, 4);
        repeat (m_wait) step();
        check("ready_low_between_pulses", {31'd0, din_ready}, 32'd0);
        if (hold_next) begin
            din = 8'hAA;
            din_valid = 1'b1;
            din_last = 1'b1;
        end
        ds_indicator = 1'b1;
        step();
        ds_indicator = 1'b0;
        for (int j = 0; j <= G + 1; j++) begin
            if (j > 0) step();
            check($sformatf("guard_ready_%0d", j), {31'd0, din_ready}, {31'd0, (j == G + 1)});
        end
        if (hold_next) begin
            cur.delete();
            cur.push_back(8'hAA);
            push_expected(model_crc(), 3);
            step();
            din_valid = 1'b0;
            din_last = 1'b0;
            din = 8'h00;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        din = 8'h00;
        din_valid = 1'b0;
        din_last = 1'b0;
        ds_indicator = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_din_ready", {31'd0, din_ready}, 32'd1);

        cur.delete();
        for (int i = 0; i < 9; i++) cur.push_back(8'h31 + 8'(i));
        push_expected(16'h29B1, 11);
        drive_frame(1'b1, -1, 0, 1'b0);
        finish_frame(9, 1'b0);

        cur.delete();
        cur.push_back(8'h00);
        push_expected(16'hE1F0, 3);
        drive_frame(1'b1, -1, 0, 1'b0);
        finish_frame(1, 1'b0);

        cur.delete();
        for (int i = 0; i < 9; i++) cur.push_back(8'h31 + 8'(i));
        push_expected(16'h29B1, 11);
        drive_frame(1'b1, 3, 3, 1'b0);
        finish_frame(9, 1'b1);
        finish_frame(1, 1'b0);

        cur.delete();
        for (int i = 0; i < MAXP + 1; i++) cur.push_back(8'($urandom));
        drive_frame(1'b0, -1, 0, 1'b0);
        exp_err++;
        check("overflow_error_pulse", {31'd0, error}, 32'd1);
        check("overflow_ready", {31'd0, din_ready}, 32'd1);
        step();
        check("overflow_error_one_cycle", {31'd0, error}, 32'd0);

        cur.delete();
        for (int i = 0; i < MAXP; i++) cur.push_back(8'($urandom));
        push_expected(model_crc(), MAXP + 2);
        drive_frame(1'b1, -1, 0, 1'b0);
        finish_frame(MAXP, 1'b0);

        cur.delete();
        for (int i = 0; i < 6; i++) cur.push_back(8'($urandom));
        push_expected(model_crc(), 3);
        drive_frame(1'b1, -1, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midemit_reset_valid", {31'd0, dout_valid}, 32'd0);
        check("midemit_reset_dout", {24'd0, dout}, 32'd0);
        check("midemit_reset_ready", {31'd0, din_ready}, 32'd1);

        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, MAXP);
            cur.delete();
            for (int i = 0; i < n; i++) cur.push_back(8'($urandom));
            push_expected(model_crc(), n + 2);
            drive_frame(1'b1, -1, 0, 1'b1);
            finish_frame(n, 1'b0);
        end

        repeat (8) step();
        check("scoreboard_bytes_drained", exp_byte_q.size(), 0);
        check("scoreboard_bursts_drained", exp_len_q.size(), 0);
        check("error_pulse_count", err_cycles, exp_err);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_crc_appender.md
# frame_crc_appender

- Stage directly upstream of the framing FIFO in the framing/encoding path.
- Collects one variable-length payload frame into an internal buffer and computes CRC-16/CCITT-FALSE over it.
- Then emits payload plus 2 CRC bytes as one gap-free `dout_valid` burst, because the FIFO ends reception on the first invalid cycle.
- Holds off further input until the FIFO's padding/transfer sequence has finished, tracked through the FIFO's `indicator` output.

## Interface
- `MAX_PAYLOAD`, default 18: max payload bytes. `MAX_PAYLOAD + 2` must not exceed the FIFO byte capacity (20).
- `GUARD_CYCLES`, default 16: idle cycles after the second downstream indicator pulse before accepting a new frame.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  8  payload byte.
- `din_valid`  in  1  `din` valid.
- `din_last`  in  1  qualifies the final payload byte; ignored when `din_valid=0`.
- `din_ready`  out  1  block can accept a byte this cycle.
- `dout`  out  8  byte to the FIFO's `din`.
- `dout_valid`  out  1  to the FIFO's `din_valid`.
- `ds_indicator`  in  1  the FIFO's `indicator` pulse.
- `error`  out  1  one-cycle pulse when a frame is dropped for overflow.

## Operation
- Byte accept = `din_valid & din_ready`. `din_ready` is 1 in IDLE and COLLECT, 0 elsewhere.
- State IDLE:
  - accept: store byte at index 0, `len`=1, CRC=step(0xFFFF, din).
  - If `din_last` is also set, go to EMIT; otherwise go to COLLECT.
- State COLLECT:
  - accept: store byte at `len`, `len`+1, update CRC.
  - `din_last` goes to EMIT.
  - Input gaps (`din_valid=0`) are tolerated; the block keeps waiting.
- Overflow: an accept with `len==MAX_PAYLOAD` and no `din_last`:
  - byte discarded, `error` pulses, go to IDLE with `len`=0;
  - nothing is emitted.
- State EMIT: outputs `buf[0..len-1]`, then `crc[15:8]`, then `crc[7:0]`, one byte per cycle with `dout_valid`=1 throughout. After the last CRC byte go to WAIT_DOWN.
- State WAIT_DOWN: counts `ds_indicator` pulses.
  - 1st pulse marks the start of left padding; 2nd marks the start of right padding.
  - On the 2nd pulse, go to GUARD.
- State GUARD: counts `GUARD_CYCLES` cycles, then goes to IDLE.
- CRC: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout. Width is 16 bits; `len` is `$clog2(MAX_PAYLOAD+1)` bits.
- `ds_indicator` outside WAIT_DOWN is ignored.
- Reset (any state, including mid-EMIT):
  - state=IDLE; `len`, CRC and counters cleared;
  - `dout`=0, `dout_valid`=0, `error`=0, `din_ready`=1 in the following cycle.
  - Buffer contents are don't-care.
  - The FIFO must be reset together with this block.

## Timing
- All outputs are registered except `din_ready`, which is decoded from state.
- Last byte accepted at edge k: `dout_valid`=1 for the `len+2` cycles after edges k+1 … k+len+2, then 0. There are no gaps.
- `dout`=0 whenever `dout_valid`=0.
- `error` is high for exactly the one cycle after the overflowing edge.
- A single-byte frame: accepted at edge k, bursts 3 bytes starting after edge k+1.
- The 2nd indicator pulse seen at edge m: `din_ready` returns to 1 after edge m+`GUARD_CYCLES`+1.

## Structure
- Shared package `framing_pkg`:
  - state encoding (IDLE, COLLECT, EMIT, WAIT_DOWN, GUARD);
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF;
  - FIFO_CAPACITY=20.
- Sub-module `crc16_step`: combinational next-CRC for one byte, 8 unrolled bit iterations; it is also reused by the downstream checker.
- Buffer: `MAX_PAYLOAD` x 8 register array with a read index counter in EMIT.

## Test plan
- Frame "123456789" (0x31..0x39), contiguous, `din_last` on 0x39 -> `dout` bursts 0x31..0x39, 0x29, 0xB1 over 11 consecutive cycles starting one cycle after last accept.
- Single byte 0x00 with `din_last` -> 3-byte burst 0x00, CRC hi, CRC lo matching the model (0xE1F0); `din_ready`=0 from the next cycle.
- Same 9-byte frame with 3 idle cycles between bytes 4 and 5 -> output identical to scenario 1 and gap-free.
- 19 bytes without `din_last` -> `error` pulses once after byte 19; `dout_valid` stays 0; the next frame is accepted normally.
- Frame offered during WAIT_DOWN/GUARD -> `din_ready`=0 until `GUARD_CYCLES`+1 after the 2nd `ds_indicator` pulse.
  - Check with the real FIFO attached: 18-byte payload yields 20 bytes transferred and no overlap.
- `reset` asserted for 1 cycle mid-EMIT (after 3 bytes) -> `dout_valid`=0 the next cycle, state IDLE, `din_ready`=1; a new frame then produces a correct CRC.
